// File: rtl/rhythm_pkg.sv
// Shared result encodings and elaboration-time helpers for the rhythm judgement engine.
package rhythm_pkg;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_PERFECT = 2'd1,
    RES_GOOD    = 2'd2,
    RES_MISS    = 2'd3
  } res_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/judge_note_fifo.sv
// Per-lane circular queue of expected note times; the head is the next note to grade.
module judge_note_fifo
  import rhythm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TIME_W = 10,
  localparam int IW = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CW = clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [TIME_W-1:0] din_i,
  output logic [TIME_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [TIME_W-1:0] mem_q [DEPTH];
  logic [IW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    wr_d  = push_i ? ((wr_q == IW'(DEPTH - 1)) ? '0 : wr_q + IW'(1)) : wr_q;
    rd_d  = pop_i  ? ((rd_q == IW'(DEPTH - 1)) ? '0 : rd_q + IW'(1)) : rd_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i) begin
        mem_q[wr_q] <= din_i;
      end
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/rhythm_judge.sv
// Multi-lane rhythm judgement: per-lane note queues, hit edge grading into one-deep
// result slots, round-robin drain into a single judgement stream with score/combo.
module rhythm_judge
  import rhythm_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEPTH       = 4,
  parameter int TIME_W      = 10,
  parameter int PERFECT_WIN = 2,
  parameter int GOOD_WIN    = 5,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int SCORE_W     = 11,
  parameter int COMBO_W     = 8,
  localparam int LW = (LANES > 1) ? clog2(LANES) : 1
) (
  input  logic               CLOCK50M,
  input  logic               RESET_N,
  input  logic               clear,
  input  logic [TIME_W-1:0]  game_time,
  input  logic               note_valid,
  input  logic [LW-1:0]      note_lane,
  input  logic [TIME_W-1:0]  note_time,
  output logic               note_ready,
  input  logic [LANES-1:0]   hit,
  output logic               judge_valid,
  output logic [LW-1:0]      judge_lane,
  output logic [1:0]         judge_result,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [LANES-1:0]   lane_pending
);

  localparam int DW  = TIME_W + 2;
  localparam int SW1 = SCORE_W + 1;
  localparam logic signed [DW-1:0] PW_P = DW'(PERFECT_WIN);
  localparam logic signed [DW-1:0] GW_P = DW'(GOOD_WIN);
  localparam logic signed [DW-1:0] PW_N = -PW_P;
  localparam logic signed [DW-1:0] GW_N = -GW_P;

  logic [LANES-1:0]     hit_q, hit_req_q, hit_req_d;
  logic [LANES-1:0]     push_s, pop_s, empty_s, full_s;
  res_e                 slot_q [LANES];
  res_e                 slot_d [LANES];
  logic [TIME_W-1:0]    head_s [LANES];
  logic signed [DW-1:0] d_s    [LANES];
  logic [LW-1:0]        ptr_q, ptr_d, grant_lane_s, cand_s;
  logic                 grant_s;
  res_e                 grant_res_s;
  int                   idx_s;
  logic [SW1-1:0]       pts_s, score_sum_s;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d, max_combo_q, max_combo_d;
  logic                 judge_valid_q;
  logic [LW-1:0]        judge_lane_q;
  res_e                 judge_result_q;

  assign note_ready = !full_s[note_lane];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign push_s[l] = note_valid && note_ready && !clear && (note_lane == LW'(l));
    assign d_s[l]    = $signed({2'b00, game_time}) - $signed({2'b00, head_s[l]});
    judge_note_fifo #(.DEPTH(DEPTH), .TIME_W(TIME_W)) u_fifo (
      .clk_i(CLOCK50M), .rst_n_i(RESET_N), .clear_i(clear),
      .push_i(push_s[l]), .pop_i(pop_s[l]), .din_i(note_time),
      .head_o(head_s[l]), .empty_o(empty_s[l]), .full_o(full_s[l])
    );
  end

  // Round-robin pick of the first full slot at or after the pointer.
  always_comb begin
    grant_s      = 1'b0;
    grant_lane_s = '0;
    idx_s        = 0;
    cand_s       = '0;
    for (int i = 0; i < LANES; i++) begin
      idx_s = int'(ptr_q) + i;
      if (idx_s >= LANES) begin
        idx_s = idx_s - LANES;
      end else begin
        idx_s = idx_s;
      end
      cand_s = LW'(idx_s);
      if (!grant_s && (slot_q[cand_s] != RES_NONE)) begin
        grant_s      = 1'b1;
        grant_lane_s = cand_s;
      end else begin
        grant_s      = grant_s;
      end
    end
    grant_res_s = grant_s ? slot_q[grant_lane_s] : RES_NONE;
    if (grant_s) begin
      ptr_d = (grant_lane_s == LW'(LANES - 1)) ? '0 : grant_lane_s + LW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Grade each lane's head note while its result slot is empty; late notes miss first.
  always_comb begin
    pop_s     = '0;
    hit_req_d = hit_req_q | (hit & ~hit_q);
    for (int l = 0; l < LANES; l++) begin
      slot_d[l] = slot_q[l];
      if (grant_s && (grant_lane_s == LW'(l))) begin
        slot_d[l] = RES_NONE;
      end else if (slot_q[l] != RES_NONE) begin
        slot_d[l] = slot_q[l];
      end else if (empty_s[l]) begin
        hit_req_d[l] = 1'b0;
      end else if (d_s[l] > GW_P) begin
        pop_s[l]  = 1'b1;
        slot_d[l] = RES_MISS;
      end else if (hit_req_d[l]) begin
        hit_req_d[l] = 1'b0;
        if ((d_s[l] >= PW_N) && (d_s[l] <= PW_P)) begin
          pop_s[l]  = 1'b1;
          slot_d[l] = RES_PERFECT;
        end else if (d_s[l] >= GW_N) begin
          pop_s[l]  = 1'b1;
          slot_d[l] = RES_GOOD;
        end else begin
          pop_s[l]  = 1'b0;
        end
      end else begin
        slot_d[l] = RES_NONE;
      end
    end
  end

  // Saturating score and combo for the granted judgement.
  always_comb begin
    pts_s       = (grant_res_s == RES_PERFECT) ? SW1'(PERFECT_PTS) : SW1'(GOOD_PTS);
    score_sum_s = {1'b0, score_q} + pts_s;
    score_d     = (score_sum_s > {1'b0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
    combo_d     = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Lane state, arbiter pointer and registered judgement outputs.
  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_q          <= '1;
      hit_req_q      <= '0;
      slot_q         <= '{default: RES_NONE};
      ptr_q          <= '0;
      judge_valid_q  <= 1'b0;
      judge_lane_q   <= '0;
      judge_result_q <= RES_NONE;
      score_q        <= '0;
      combo_q        <= '0;
      max_combo_q    <= '0;
    end else if (clear) begin
      hit_q          <= '1;
      hit_req_q      <= '0;
      slot_q         <= '{default: RES_NONE};
      ptr_q          <= '0;
      judge_valid_q  <= 1'b0;
      judge_lane_q   <= '0;
      judge_result_q <= RES_NONE;
      score_q        <= '0;
      combo_q        <= '0;
      max_combo_q    <= '0;
    end else begin
      hit_q          <= hit;
      hit_req_q      <= hit_req_d;
      slot_q         <= slot_d;
      ptr_q          <= ptr_d;
      judge_valid_q  <= grant_s;
      judge_lane_q   <= grant_lane_s;
      judge_result_q <= grant_res_s;
      if (grant_s && (grant_res_s == RES_MISS)) begin
        combo_q <= '0;
      end else if (grant_s) begin
        score_q     <= score_d;
        combo_q     <= combo_d;
        max_combo_q <= max_combo_d;
      end else begin
        combo_q <= combo_q;
      end
    end
  end

  assign judge_valid  = judge_valid_q;
  assign judge_lane   = judge_lane_q;
  assign judge_result = judge_result_q;
  assign score        = score_q;
  assign combo        = combo_q;
  assign max_combo    = max_combo_q;
  assign lane_pending = ~empty_s;

endmodule

// File: tb/tb_rhythm_judge.sv
// Self-checking bench for rhythm_judge: directed scenarios plus random play against a note-level model.
module tb_rhythm_judge;

  logic        CLOCK50M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  game_time = 10'd0;
  logic        note_valid = 1'b0;
  logic [1:0]  note_lane = 2'd0;
  logic [9:0]  note_time = 10'd0;
  logic [3:0]  hit = 4'd0;
  logic        note_ready, judge_valid, s2_ready, s2_valid;
  logic [1:0]  judge_lane, judge_result, s2_lane, s2_result;
  logic [10:0] score;
  logic [7:0]  combo, max_combo;
  logic [3:0]  lane_pending, s2_pending, s2_score;
  logic [1:0]  s2_combo, s2_max;

  always #5 CLOCK50M = ~CLOCK50M;

  rhythm_judge dut (
    .CLOCK50M(CLOCK50M), .RESET_N(RESET_N), .clear(clear), .game_time(game_time),
    .note_valid(note_valid), .note_lane(note_lane), .note_time(note_time), .note_ready(note_ready),
    .hit(hit), .judge_valid(judge_valid), .judge_lane(judge_lane), .judge_result(judge_result),
    .score(score), .combo(combo), .max_combo(max_combo), .lane_pending(lane_pending)
  );

  rhythm_judge #(.SCORE_W(4), .COMBO_W(2)) dut_s (
    .CLOCK50M(CLOCK50M), .RESET_N(RESET_N), .clear(clear), .game_time(game_time),
    .note_valid(note_valid), .note_lane(note_lane), .note_time(note_time), .note_ready(s2_ready),
    .hit(hit), .judge_valid(s2_valid), .judge_lane(s2_lane), .judge_result(s2_result),
    .score(s2_score), .combo(s2_combo), .max_combo(s2_max), .lane_pending(s2_pending)
  );

  int errors = 0;
  int checks = 0;

  // Note-level reference: queues of note times, pending grade per lane, sticky presses.
  int       mq [4][$];
  int       mslot [4];
  bit [3:0] mreq, mprev;
  int       mptr;
  logic       m_jv;
  logic [1:0] m_jl, m_jr;
  logic [3:0] m_pend;
  int m_score, m_combo, m_max, m2_score, m2_combo, m2_max;

  logic [43:0] dut_vec;
  assign dut_vec = {judge_valid, judge_lane, judge_result, score, combo, max_combo, lane_pending,
                    s2_score, s2_combo, s2_max};

  function automatic logic [43:0] model_vec();
    return {m_jv, m_jl, m_jr, 11'(m_score), 8'(m_combo), 8'(m_max), m_pend,
            4'(m2_score), 2'(m2_combo), 2'(m2_max)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mslot[k] = 0;
    end
    mreq = 4'd0; mprev = 4'hF; mptr = 0;
    m_jv = 1'b0; m_jl = 2'd0; m_jr = 2'd0; m_pend = 4'd0;
    m_score = 0; m_combo = 0; m_max = 0; m2_score = 0; m2_combo = 0; m2_max = 0;
  endtask

  task automatic model_step();
    int  old_slot [4];
    bit [3:0] req;
    bit  rdy, found;
    int  l, d, p;
    if (clear) begin
      model_reset();
      return;
    end
    rdy = (mq[note_lane].size() < 4);
    old_slot = mslot;
    m_jv = 1'b0; m_jl = 2'd0; m_jr = 2'd0; found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      l = (mptr + i) % 4;
      if (!found && old_slot[l] != 0) begin
        found = 1'b1; m_jv = 1'b1; m_jl = 2'(l); m_jr = 2'(old_slot[l]);
        mslot[l] = 0; mptr = (l + 1) % 4;
      end
    end
    if (found && m_jr == 2'd3) begin
      m_combo = 0; m2_combo = 0;
    end else if (found) begin
      p = (m_jr == 2'd1) ? 3 : 1;
      m_score  = (m_score + p > 2047) ? 2047 : m_score + p;
      m2_score = (m2_score + p > 15) ? 15 : m2_score + p;
      m_combo  = (m_combo < 255) ? m_combo + 1 : 255;
      m2_combo = (m2_combo < 3) ? m2_combo + 1 : 3;
      if (m_combo > m_max) m_max = m_combo;
      if (m2_combo > m2_max) m2_max = m2_combo;
    end
    req = mreq | (hit & ~mprev);
    for (int k = 0; k < 4; k++) begin
      if (old_slot[k] == 0) begin
        if (mq[k].size() == 0) begin
          req[k] = 1'b0;
        end else begin
          d = int'(game_time) - mq[k][0];
          if (d > 5) begin
            void'(mq[k].pop_front()); mslot[k] = 3;
          end else if (req[k]) begin
            req[k] = 1'b0;
            if (d >= -2 && d <= 2) begin
              void'(mq[k].pop_front()); mslot[k] = 1;
            end else if (d >= -5) begin
              void'(mq[k].pop_front()); mslot[k] = 2;
            end
          end
        end
      end
    end
    mreq = req;
    mprev = hit;
    if (note_valid && rdy) mq[note_lane].push_back(int'(note_time));
    for (int k = 0; k < 4; k++) m_pend[k] = (mq[k].size() != 0);
  endtask

  task automatic tick();
    @(posedge CLOCK50M);
    if (!RESET_N) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; note_valid = 1'b0; hit = 4'd0; game_time = 10'd0;
    tick();
    clear = 1'b0;
  endtask

  task automatic push(input logic [1:0] lane, input logic [9:0] t);
    note_valid = 1'b1; note_lane = lane; note_time = t;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    game_time = 10'd90;
    push(2'd0, 10'd92);
    push(2'd1, 10'd92);
    game_time = 10'd92; hit = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick(); hit = 4'd0; checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL reset_pre c%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
    #2 RESET_N = 1'b0; model_reset(); hit = 4'b0001; #1;
    checks++;
    if ({judge_valid, judge_lane, judge_result, score, combo, max_combo, lane_pending, note_ready} !==
        {1'b0, 2'd0, 2'd0, 11'd0, 8'd0, 8'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL reset_async: got %b %0d %0d %0d %0d %0d %b %b want all zero, ready 1",
        judge_valid, judge_lane, judge_result, score, combo, max_combo, lane_pending, note_ready);
    end
    tick(); tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) hit = 4'd0;
      tick(); checks++;
      if (judge_valid !== 1'b0 || dut_vec !== model_vec()) begin errors++; $display("FAIL reset_held_key c%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_perfect_early();
    do_clear();
    game_time = 10'd95;
    push(2'd0, 10'd100);
    game_time = 10'd101; hit = 4'b0001;
    tick(); hit = 4'd0; tick(); checks++;
    if ({judge_valid, judge_lane, judge_result, score, combo} !== {1'b1, 2'd0, 2'd1, 11'd3, 8'd1}) begin
      errors++; $display("FAIL perfect: got v%b l%0d r%0d s%0d c%0d want v1 l0 r1 s3 c1", judge_valid, judge_lane, judge_result, score, combo);
    end
    do_clear();
    game_time = 10'd90;
    push(2'd0, 10'd100);
    game_time = 10'd94; hit = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick(); hit = 4'd0; checks++;
      if (judge_valid !== 1'b0 || lane_pending[0] !== 1'b1 || dut_vec !== model_vec()) begin
        errors++; $display("FAIL early_hit c%0d: got %h want %h", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_good_miss();
    do_clear();
    game_time = 10'd90;
    push(2'd1, 10'd100);
    push(2'd2, 10'd100);
    game_time = 10'd104; hit = 4'b0010;
    tick(); hit = 4'd0; tick(); checks++;
    if ({judge_valid, judge_lane, judge_result, score, combo} !== {1'b1, 2'd1, 2'd2, 11'd1, 8'd1}) begin
      errors++; $display("FAIL good: got v%b l%0d r%0d s%0d c%0d want v1 l1 r2 s1 c1", judge_valid, judge_lane, judge_result, score, combo);
    end
    game_time = 10'd105;
    tick(); checks++;
    if (dut_vec !== model_vec()) begin errors++; $display("FAIL no_early_miss: got %h want %h", dut_vec, model_vec()); end
    game_time = 10'd106;
    tick(); tick(); checks++;
    if ({judge_valid, judge_lane, judge_result, combo, max_combo} !== {1'b1, 2'd2, 2'd3, 8'd0, 8'd1}) begin
      errors++; $display("FAIL miss: got v%b l%0d r%0d c%0d m%0d want v1 l2 r3 c0 m1", judge_valid, judge_lane, judge_result, combo, max_combo);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    game_time = 10'd90;
    for (int k = 0; k < 4; k++) push(2'(k), 10'd100);
    game_time = 10'd100; hit = 4'hF;
    tick(); hit = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick(); checks++;
      if ({judge_valid, judge_lane, judge_result} !== {1'b1, 2'(k), 2'd1}) begin
        errors++; $display("FAIL b2b_%0d: got v%b l%0d r%0d want v1 l%0d r1", k, judge_valid, judge_lane, judge_result, k);
      end
    end
    checks++;
    if ({score, combo} !== {11'd12, 8'd4}) begin
      errors++; $display("FAIL b2b_totals: got s%0d c%0d want s12 c4", score, combo);
    end
  endtask

  task automatic test_full();
    do_clear();
    game_time = 10'd10;
    for (int k = 0; k < 4; k++) push(2'd2, 10'(50 + k));
    note_valid = 1'b1; note_lane = 2'd2; note_time = 10'd54; #1; checks++;
    if (note_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", note_ready); end
    tick();
    note_valid = 1'b1; note_lane = 2'd3; note_time = 10'd60; #1; checks++;
    if (note_ready !== 1'b1) begin errors++; $display("FAIL other_lane_ready: got %b want 1", note_ready); end
    tick();
    note_valid = 1'b0; note_lane = 2'd2; game_time = 10'd50; hit = 4'b0100;
    tick(); hit = 4'd0; checks++;
    if (note_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b want 1", note_ready); end
    game_time = 10'd70;
    for (int c = 0; c < 12; c++) begin
      tick(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL full_drain c%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
  endtask

  task automatic test_saturation();
    do_clear();
    game_time = 10'd10;
    for (int k = 0; k < 6; k++) push(2'(k % 2), 10'd20);
    game_time = 10'd20;
    for (int c = 0; c < 18; c++) begin
      hit = (c % 2 == 0 && c < 14) ? 4'b0011 : 4'd0;
      tick(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL sat_run c%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
    checks++;
    if ({score, combo, max_combo, s2_score, s2_combo, s2_max} !== {11'd18, 8'd6, 8'd6, 4'd15, 2'd3, 2'd3}) begin
      errors++; $display("FAIL saturate: got %0d %0d %0d / %0d %0d %0d want 18 6 6 / 15 3 3", score, combo, max_combo, s2_score, s2_combo, s2_max);
    end
    clear = 1'b1; tick(); clear = 1'b0; checks++;
    if ({score, combo, max_combo, s2_score, s2_combo, s2_max} !== 27'd0) begin
      errors++; $display("FAIL clear_counters: got %0d %0d %0d / %0d %0d %0d want all 0", score, combo, max_combo, s2_score, s2_combo, s2_max);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 1500; c++) begin
      clear = ($urandom_range(0, 299) == 0);
      if (clear) game_time = 10'd0;
      else if (game_time < 10'd1000 && $urandom_range(0, 2) == 0) game_time = game_time + 10'd1;
      note_valid = ($urandom_range(0, 2) == 0);
      note_lane  = 2'($urandom);
      note_time  = game_time + 10'($urandom_range(0, 12));
      hit        = 4'($urandom) & 4'($urandom);
      #1; checks++;
      if (note_ready !== (mq[note_lane].size() < 4)) begin errors++; $display("FAIL rand_ready c%0d: got %b", c, note_ready); end
      tick(); checks++;
      if (dut_vec !== model_vec()) begin errors++; $display("FAIL rand c%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
    clear = 1'b0; note_valid = 1'b0; hit = 4'd0;
  endtask

  initial begin
    model_reset();
    tick(); tick();
    RESET_N = 1'b1;
    test_reset();
    test_perfect_early();
    test_good_miss();
    test_back_to_back();
    test_full();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rhythm_judge.md
# rhythm_judge

Parametrised multi-lane judgement engine for the rhythm game; successor to the fixed single-pattern score calculator. Holds a per-lane queue of expected note times, detects rising edges on each lane's hit key, and grades every note as perfect, good or miss against the 0.1 s game clock. It accumulates a saturating score and combo, and emits one judgement event per cycle to the display/LED logic.

## Interface
Parameters:
- LANES, 4, number of key lanes (≥1)
- DEPTH, 4, note queue depth per lane (power of 2)
- TIME_W, 10, game clock width
- PERFECT_WIN, 2, max |game_time − note_time| for perfect
- GOOD_WIN, 5, max |game_time − note_time| for good (≥ PERFECT_WIN)
- PERFECT_PTS, 3 / GOOD_PTS, 1, points per grade
- SCORE_W, 11 / COMBO_W, 8, counter widths

Ports:
- CLOCK50M  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- clear  in  1  synchronous game restart
- game_time  in  TIME_W  game clock, monotonic non-decreasing, no wrap
- note_valid  in  1  note push request
- note_lane  in  clog2(LANES)  target lane of push
- note_time  in  TIME_W  expected hit time of pushed note
- note_ready  out  1  = !full[note_lane], combinational
- hit  in  LANES  raw key levels, already synchronised
- judge_valid  out  1  one-cycle judgement pulse
- judge_lane  out  clog2(LANES)  lane of judgement
- judge_result  out  2  1 perfect, 2 good, 3 miss (0 when idle)
- score  out  SCORE_W  saturating total
- combo / max_combo  out  COMBO_W  current and best combo, saturating
- lane_pending  out  LANES  per-lane queue non-empty

## Operation
- Push accepted when note_valid && note_ready; appended to lane queue. Pushes to a full lane are not accepted. Notes pushed out of time order are graded in push order.
- Edge detect: hit_q ← hit each cycle; hit_q resets to all-ones (keys held through reset do not fire). An edge sets a sticky per-lane hit_req.
- Each lane owns a one-deep result slot. A lane evaluates only while its slot is empty. With slot empty and queue non-empty, d = game_time − head, computed signed in TIME_W+2 bits:
  - d > GOOD_WIN: pop, slot ← miss (takes priority over a same-cycle hit_req).
  - hit_req and |d| ≤ PERFECT_WIN: pop, slot ← perfect, clear hit_req.
  - hit_req and |d| ≤ GOOD_WIN: pop, slot ← good, clear hit_req.
  - hit_req and d < −GOOD_WIN: clear hit_req, no pop, no event (early stray).
- hit_req with an empty queue is cleared with no event.
- Round-robin arbiter: the grant pointer resets to lane 0. It grants the first lane with a full slot, searching from the pointer upward with wrap, then sets pointer ← granted+1. The granted slot is drained, and judge_* and counters update.
- Perfect/good: score += PTS saturating at 2^SCORE_W−1; combo += 1 saturating; max_combo ← max(max_combo, new combo). Miss: combo ← 0.
- clear: same effect as reset (queues flushed, slots emptied, counters 0, pointer 0, hit_q ← all-ones); clear has priority over all same-cycle events, and a same-cycle push is dropped.

## Timing
- Reset values: judge_valid 0, judge_lane 0, judge_result 0, score 0, combo 0, max_combo 0, lane_pending 0; note_ready 1.
- Hit edge present in cycle t (hit=1, hit_q=0), slot empty: slot filled at edge ending t; judge_valid, score and combo all visible in cycle t+2 when uncontended. Each extra contending lane ahead in round-robin order adds one cycle.
- Miss fires in the first cycle game_time = note_time+GOOD_WIN+1, with the same 2-cycle latency.
- Push in cycle t: lane_pending and head visible in t+1; a note cannot be judged in its push cycle.
- Throughput: one judgement per cycle across all lanes; each lane sustains one per 2 cycles.

## Structure
- Package rhythm_pkg: result encodings (RES_NONE/PERFECT/GOOD/MISS), clog2 function.
- Sub-module judge_note_fifo (DEPTH, TIME_W): per-lane circular queue with push, pop, head, empty, full; instantiated LANES times via generate.

## Test plan
- Reset: assert RESET_N=0 mid-activity → all outputs at reset values immediately; note_ready=1; holding hit[0]=1 through release produces no event.
- Lane 0 note at 100, hit edge at game_time 101 → judge_valid with lane 0, result 1 two cycles later; score 3, combo 1. Early hit at 94 for another note at 100 → no event, note retained.
- Lane 1 note at 100, hit at 104 → good, score +1. Lane 2 note at 100, no hit → miss in the cycle after game_time reaches 106; combo 0; max_combo unchanged.
- Four notes at 100 on lanes 0–3, all hits in one cycle at game_time 100 → four consecutive judge_valid pulses on lanes 0,1,2,3, each perfect; score +12; combo 4.
- Push 4 notes to lane 2 → note_ready low while note_lane=2; a 5th push is not accepted. A same-cycle push to lane 3 is accepted. Pop one → ready returns next cycle.
- Override SCORE_W=4, COMBO_W=2 → score saturates at 15 after 5 perfects, combo at 3; clear → all counters 0 the next cycle.
